rom_dl_router: RTL and testbench

Parametrised download router between `hps_io` ioctl signals and the game cores' ROM/DIP/mod storage. It generalises the fixed three-ROM address decode, DIP capture and mod-byte capture into N configurable regions with registered write strobes, per-region byte counters and a download sequencer. The sequencer holds the core in reset across a load and reports completion. It sits in `emu` between `hps_io` and the `dpram` instances and core DL ports.

---
 rtl/rom_dl_router.sv | 157 +++++++++++++++
 tb/tb_rom_dl_router.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_router.sv
// ioctl download router: N address regions with registered strobes, byte counters and a load sequencer.
// 1-cycle write latency, no backpressure. Optional per-region checksum under ROM_DL_CHECKSUM_EN.
module rom_dl_router #(
  parameter int NUM_REGIONS = 4,
  parameter int LOCAL_AW = 16,
  parameter logic [25*NUM_REGIONS-1:0] REGION_BASE = {25'hFF00, 25'hE000, 25'h0, 25'h0},
  parameter logic [5*NUM_REGIONS-1:0] REGION_LOG2 = {5'd16, 5'd12, 5'd15, 5'd16},
  parameter int ROM_INDEX = 0,
  parameter int MOD_INDEX = 1,
  parameter int DIP_INDEX = 254,
  parameter int DIP_BYTES = 8
) (
  input  logic                                clk_sys,
  input  logic                                reset,
  input  logic                                ioctl_download,
  input  logic                                ioctl_wr,
  input  logic [7:0]                          ioctl_index,
  input  logic [24:0]                         ioctl_addr,
  input  logic [7:0]                          ioctl_dout,
  output logic [NUM_REGIONS-1:0]              wr_en,
  output logic [LOCAL_AW-1:0]                 wr_addr,
  output logic [7:0]                          wr_data,
  output logic [NUM_REGIONS*(LOCAL_AW+1)-1:0] region_cnt,
  output logic [NUM_REGIONS-1:0]              region_full,
  output logic [8*DIP_BYTES-1:0]              dip,
  output logic [7:0]                          mod_byte,
  output logic                                mod_valid,
  output logic                                core_hold,
  output logic                                rom_ready,
  output logic                                load_done,
  output logic [NUM_REGIONS*16-1:0]           region_sum
);

  localparam int CW = LOCAL_AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOADING = 2'd1, FLUSH = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic                   dl_q;
  logic                   rise, fall, clr, accept, dip_wr, mod_wr;
  logic [25:0]            off [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] hit;
  logic [LOCAL_AW-1:0]    laddr;
  logic [CW-1:0]          cnt [NUM_REGIONS];

  assign rise   = ioctl_download & ~dl_q & (ioctl_index == 8'(ROM_INDEX));
  assign fall   = ~ioctl_download & dl_q;
  assign accept = ioctl_wr & ioctl_download & (ioctl_index == 8'(ROM_INDEX)) & (state == LOADING);
  assign dip_wr = ioctl_wr & (ioctl_index == 8'(DIP_INDEX));
  assign mod_wr = ioctl_wr & (ioctl_index == 8'(MOD_INDEX));

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = LOADING;
          clr       = 1'b1;
        end
      end
      LOADING: if (fall) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dl_q resets high so a download held across reset release never looks like a rising edge
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dl_q      <= 1'b1;
      core_hold <= 1'b0;
      rom_ready <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      dl_q      <= ioctl_download;
      core_hold <= (state_nxt != IDLE);
      load_done <= (state == FLUSH);
      if (clr)
        rom_ready <= 1'b0;
      else if (state == FLUSH)
        rom_ready <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    localparam logic [CW-1:0] SZ = CW'(1) << REGION_LOG2[5*g +: 5];

    assign off[g] = {1'b0, ioctl_addr} - {1'b0, REGION_BASE[25*g +: 25]};
    assign hit[g] = ~off[g][25] && ((off[g][24:0] >> REGION_LOG2[5*g +: 5]) == 25'd0);
    assign region_full[g] = (cnt[g] == SZ);
    assign region_cnt[CW*g +: CW] = cnt[g];

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
        cnt[g] <= '0;
      else if (clr)
        cnt[g] <= '0;
      else if (accept && hit[g] && !region_full[g])
        cnt[g] <= cnt[g] + CW'(1);
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] sum;
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
        sum <= '0;
      else if (clr)
        sum <= '0;
      else if (accept && hit[g] && !region_full[g])
        sum <= sum + {8'd0, ioctl_dout};
    end
    assign region_sum[16*g +: 16] = sum;
`else
    assign region_sum[16*g +: 16] = 16'd0;
`endif
  end

  // One shared local address: the highest-numbered matching region supplies the offset
  always_comb begin
    laddr = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (hit[i]) laddr = off[i][LOCAL_AW-1:0];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept ? hit : '0;
      if (accept && (|hit)) begin
        wr_addr <= laddr;
        wr_data <= ioctl_dout;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip       <= '0;
      mod_byte  <= '0;
      mod_valid <= 1'b0;
    end else begin
      for (int k = 0; k < DIP_BYTES; k++)
        if (dip_wr && (ioctl_addr == 25'(k))) dip[8*k +: 8] <= ioctl_dout;
      if (mod_wr) begin
        mod_byte  <= ioctl_dout;
        mod_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router (default parameters): vector table, directed load sequences, random writes vs model.
module tb_rom_dl_router;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int CW = AW + 1;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic [NR-1:0] wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [NR*CW-1:0] region_cnt;
  logic [NR-1:0] region_full;
  logic [63:0]   dip;
  logic [7:0]    mod_byte;
  logic          mod_valid, core_hold, rom_ready, load_done;
  logic [NR*16-1:0] region_sum;

  rom_dl_router dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .region_cnt(region_cnt),
    .region_full(region_full), .dip(dip), .mod_byte(mod_byte), .mod_valid(mod_valid),
    .core_hold(core_hold), .rom_ready(rom_ready), .load_done(load_done), .region_sum(region_sum)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  // Region map as the spec defines it: bases and log2 sizes
  int base [NR] = '{0, 0, 'hE000, 'hFF00};
  int lg2  [NR] = '{16, 15, 12, 16};

  int          m_cnt [NR];
  int          m_sum [NR];
  int          n_str [NR];
  int          m_wraddr, m_wrdata;
  logic        m_loading;
  logic [63:0] m_dip;

  typedef struct {
    int         addr;
    int         data;
    logic [3:0] en;
    int         laddr;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [3:0] m_hit(input int addr);
    logic [3:0] h = '0;
    for (int i = 0; i < NR; i++)
      if (addr >= base[i] && (addr - base[i]) < (1 << lg2[i])) h[i] = 1'b1;
    return h;
  endfunction

  function automatic int m_laddr(input int addr);
    int r = 0;
    for (int i = 0; i < NR; i++)
      if (addr >= base[i] && (addr - base[i]) < (1 << lg2[i])) r = (addr - base[i]) & 'hFFFF;
    return r;
  endfunction

  task automatic model_clear_counts();
    for (int i = 0; i < NR; i++) begin
      m_cnt[i] = 0;
      m_sum[i] = 0;
    end
  endtask

  task automatic rom_wr(input int addr, input int data);
    logic [3:0] eh;
    ioctl_index = 8'd0;
    ioctl_wr    = 1'b1;
    ioctl_addr  = 25'(addr);
    ioctl_dout  = 8'(data);
    tick();
    ioctl_wr = 1'b0;
    eh = m_loading ? m_hit(addr) : 4'b0;
    if (eh != 0) begin
      m_wraddr = m_laddr(addr);
      m_wrdata = data & 'hFF;
    end
    for (int i = 0; i < NR; i++) begin
      if (eh[i] && m_cnt[i] < (1 << lg2[i])) begin
        m_cnt[i]++;
`ifdef ROM_DL_CHECKSUM_EN
        m_sum[i] = (m_sum[i] + (data & 'hFF)) & 'hFFFF;
`endif
      end
      if (wr_en[i]) n_str[i]++;
    end
    chk("wr_en", 64'(wr_en), 64'(eh));
    chk("wr_addr", 64'(wr_addr), 64'(m_wraddr));
    chk("wr_data", 64'(wr_data), 64'(m_wrdata));
    chk("core_hold_wr", 64'(core_hold), 64'(m_loading));
  endtask

  task automatic idle_cyc();
    tick();
    chk("idle_wr_en", 64'(wr_en), 64'd0);
    chk("idle_wr_addr", 64'(wr_addr), 64'(m_wraddr));
  endtask

  task automatic check_cnts();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("region_cnt[%0d]", i), 64'(region_cnt[CW*i +: CW]), 64'(m_cnt[i]));
      chk($sformatf("region_full[%0d]", i), 64'(region_full[i]), 64'(m_cnt[i] == (1 << lg2[i])));
      chk($sformatf("region_sum[%0d]", i), 64'(region_sum[16*i +: 16]), 64'(m_sum[i]));
    end
  endtask

  task automatic start_load();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    m_loading = 1'b1;
    model_clear_counts();
    for (int i = 0; i < NR; i++) n_str[i] = 0;
    chk("start_core_hold", 64'(core_hold), 64'd1);
    chk("start_rom_ready", 64'(rom_ready), 64'd0);
    chk("start_wr_en", 64'(wr_en), 64'd0);
  endtask

  task automatic end_load();
    ioctl_download = 1'b0;
    tick();
    chk("flush_core_hold", 64'(core_hold), 64'd1);
    chk("flush_load_done", 64'(load_done), 64'd0);
    m_loading = 1'b0;
    tick();
    chk("done_core_hold", 64'(core_hold), 64'd0);
    chk("done_pulse", 64'(load_done), 64'd1);
    chk("done_rom_ready", 64'(rom_ready), 64'd1);
    tick();
    chk("done_pulse_end", 64'(load_done), 64'd0);
    chk("rom_ready_hold", 64'(rom_ready), 64'd1);
  endtask

  task automatic dip_wr(input int addr, input int data);
    ioctl_index = 8'd254;
    ioctl_wr    = 1'b1;
    ioctl_addr  = 25'(addr);
    ioctl_dout  = 8'(data);
    tick();
    ioctl_wr = 1'b0;
    if (addr < 8) m_dip[8*addr +: 8] = 8'(data);
    chk("dip", dip, m_dip);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_cnt"}, 64'(region_cnt), 64'd0);
    chk({tag, "_full"}, 64'(region_full), 64'd0);
    chk({tag, "_sum"}, region_sum, 64'd0);
    chk({tag, "_dip"}, dip, 64'd0);
    chk({tag, "_mod"}, {55'd0, mod_valid, mod_byte}, 64'd0);
    chk({tag, "_ctl"}, {61'd0, core_hold, rom_ready, load_done}, 64'd0);
  endtask

  initial begin
    tv[0] = '{'h00010, 'h11, 4'b0011, 'h0010};
    tv[1] = '{'h07FFF, 'h22, 4'b0011, 'h7FFF};
    tv[2] = '{'h08000, 'h33, 4'b0001, 'h8000};
    tv[3] = '{'h0E005, 'h44, 4'b0101, 'h0005};
    tv[4] = '{'h0FF10, 'h5A, 4'b1001, 'h0010};
    tv[5] = '{'h10000, 'h66, 4'b1000, 'h0100};
    tv[6] = '{'h1FF00, 'h77, 4'b0000, 'h0100};
    tv[7] = '{'h1FEFF, 'h88, 4'b1000, 'hFFFF};
    tv[8] = '{'h0F000, 'h99, 4'b0001, 'hF000};
    tv[9] = '{'h0EFFF, 'hAA, 4'b0101, 'h0FFF};

    m_loading = 1'b0;
    m_wraddr  = 0;
    m_wrdata  = 0;
    m_dip     = '0;
    model_clear_counts();

    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Region decode table, including overlap and unmatched addresses
    start_load();
    for (int i = 0; i < 10; i++) begin
      rom_wr(tv[i].addr, tv[i].data);
      chk($sformatf("tv%0d_en", i), 64'(wr_en), 64'(tv[i].en));
      chk($sformatf("tv%0d_addr", i), 64'(wr_addr), 64'(tv[i].laddr));
    end
    idle_cyc();
    end_load();
    check_cnts();

    // Writes after completion are ignored
    rom_wr('h0100, 'h12);

    // Full load of 0x0000..0x7FFF and 0xE000..0xEFFF
    start_load();
    for (int a = 0; a < 'h8000; a++) rom_wr(a, (a * 7) & 'hFF);
    for (int a = 'hE000; a < 'hF000; a++) rom_wr(a, a & 'hFF);
    end_load();
    chk("strobes_r1", 64'(n_str[1]), 64'd32768);
    chk("strobes_r2", 64'(n_str[2]), 64'd4096);
    chk("full_r1", 64'(region_full[1]), 64'd1);
    chk("cnt_r0_total", 64'(region_cnt[0 +: CW]), 64'd36864);
    check_cnts();

    // Saturation of region 2 (4 KiB) with repeated addresses
    start_load();
    for (int i = 0; i < 4200; i++) rom_wr('hE000 + (i % 4096), i & 'hFF);
    chk("sat_r2", 64'(region_cnt[2*CW +: CW]), 64'd4096);
    for (int i = 0; i < 5; i++) idle_cyc();
    chk("sat_r2_hold", 64'(region_cnt[2*CW +: CW]), 64'd4096);
    end_load();
    check_cnts();

    // Random writes and gaps against the model
    start_load();
    for (int n = 0; n < 1500; n++) begin
      int a;
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 9) == 0) a = int'($urandom & 32'h01FF_FFFF);
        else a = int'($urandom_range(0, 'h1FFFF));
        rom_wr(a, int'($urandom_range(0, 255)));
      end else begin
        idle_cyc();
      end
    end
    end_load();
    check_cnts();

    // DIP and mod capture, and a non-ROM download staying idle
    dip_wr(0, 'h11);
    dip_wr(3, 'hA5);
    chk("dip_byte3", 64'(dip[31:24]), 64'hA5);
    dip_wr(8, 'hEE);
    dip_wr(7, 'h3C);
    ioctl_index = 8'd1;
    ioctl_wr    = 1'b1;
    ioctl_dout  = 8'h04;
    tick();
    ioctl_wr = 1'b0;
    chk("mod_byte", 64'(mod_byte), 64'h04);
    chk("mod_valid", 64'(mod_valid), 64'd1);
    chk("mod_no_state", 64'(core_hold), 64'd0);
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    tick();
    tick();
    chk("nonrom_dl_idle", 64'(core_hold), 64'd0);
    ioctl_download = 1'b0;
    tick();

    // Checksum of three 0xFF bytes
    start_load();
    for (int i = 0; i < 3; i++) rom_wr('h0100, 'hFF);
`ifdef ROM_DL_CHECKSUM_EN
    chk("sum_r1", 64'(region_sum[16 +: 16]), 64'h02FD);
`else
    chk("sum_r1", 64'(region_sum[16 +: 16]), 64'h0000);
`endif
    end_load();
    check_cnts();

    // Reset mid-load while the download stays asserted
    start_load();
    for (int i = 0; i < 4; i++) rom_wr('h0200 + i, 'h40 + i);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    tick();
    reset = 1'b0;
    m_loading = 1'b0;
    m_wraddr  = 0;
    m_wrdata  = 0;
    m_dip     = '0;
    model_clear_counts();
    tick();
    rom_wr('h0300, 'h55);
    chk("post_rst_hold", 64'(core_hold), 64'd0);
    ioctl_download = 1'b0;
    tick();
    start_load();
    rom_wr('h0300, 'h55);
    end_load();
    check_cnts();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
